// File: rtl/sigma_delta_decimator_if.sv
// Sample-stream interface of the sigma-delta decimator: modulator-rate input side
// and audio-rate PCM side.
interface sigma_delta_decimator_if #(
  parameter int InputN  = 8,
  parameter int OutputN = 24
);
  logic               Clk_Ena;
  logic [InputN-1:0]  Input;
  logic [OutputN-1:0] Output;
  logic               Output_Valid;
  logic               Settled;

  modport master (
    output Clk_Ena, Input,
    input  Output, Output_Valid, Settled
  );

  modport slave (
    input  Clk_Ena, Input,
    output Output, Output_Valid, Settled
  );
endinterface

// File: rtl/sigma_delta_decimator.sv
// Order-N CIC decimator (decimate by 2^RLog2) with round/saturate to OutputN bits.
// Rebuilds high-resolution PCM from a low-width noise-shaped sample stream.
module sigma_delta_decimator #(
  parameter int InputN  = 8,
  parameter int OutputN = 24,
  parameter int N       = 4,
  parameter int RLog2   = 6
) (
  input logic                    Clk,
  input logic                    Reset,
  sigma_delta_decimator_if.slave bus
);
  localparam int W     = InputN + N * RLog2;
  localparam int Shift = W - OutputN;
  localparam int ScW   = $clog2(N + 1);
  localparam logic signed [W:0] RndK = (W + 1)'(1) << (Shift - 1);

  logic signed [InputN-1:0] s_n;
  logic signed [W-1:0]      s;
  logic signed [W-1:0]      integ [N];
  logic [RLog2-1:0]         dec_cnt;
  logic                     cap_req;
  logic [N:0]               tok;
  logic signed [W-1:0]      pipe_q [N+1];
  logic signed [W-1:0]      dly [N];
  logic signed [W:0]        rnd_sum;
  logic signed [W:0]        sh;
  logic                     fits;
  logic [OutputN-1:0]       sat;
  logic [OutputN-1:0]       out_q;
  logic                     valid_q;
  logic                     settled_q;
  logic [ScW-1:0]           strobe_cnt;

  assign s_n = {~bus.Input[InputN-1], bus.Input[InputN-2:0]};
  assign s   = {{(W-InputN){s_n[InputN-1]}}, s_n};

  // Integrators wrap freely; the combs cancel the wrap exactly.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < N; k++) integ[k] <= '0;
      dec_cnt <= '0;
      cap_req <= 1'b0;
    end else begin
      cap_req <= bus.Clk_Ena && (&dec_cnt);
      if (bus.Clk_Ena) begin
        dec_cnt  <= dec_cnt + RLog2'(1);
        integ[0] <= integ[0] + s;
        for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
      end
    end
  end

  // pipe_q[0] holds the decimated integrator value; pipe_q[k] is comb stage k.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tok <= '0;
      for (int k = 0; k <= N; k++) pipe_q[k] <= '0;
      for (int k = 0; k < N; k++) dly[k] <= '0;
    end else begin
      tok[0] <= cap_req;
      if (cap_req) pipe_q[0] <= integ[N-1];
      for (int k = 1; k <= N; k++) begin
        tok[k] <= tok[k-1];
        if (tok[k-1]) begin
          pipe_q[k] <= pipe_q[k-1] - dly[k-1];
          dly[k-1]  <= pipe_q[k-1];
        end
      end
    end
  end

  assign rnd_sum = {pipe_q[N][W-1], pipe_q[N]} + RndK;
  assign sh      = rnd_sum >>> Shift;
  assign fits    = (&sh[W:OutputN-1]) | ~(|sh[W:OutputN-1]);

  always_comb begin
    sat = sh[OutputN-1:0];
    if (!fits) sat = sh[W] ? {1'b1, {(OutputN-1){1'b0}}} : {1'b0, {(OutputN-1){1'b1}}};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out_q      <= {1'b1, {(OutputN-1){1'b0}}};
      valid_q    <= 1'b0;
      settled_q  <= 1'b0;
      strobe_cnt <= '0;
    end else begin
      valid_q <= tok[N];
      if (tok[N]) begin
        out_q <= {~sat[OutputN-1], sat[OutputN-2:0]};
        if (strobe_cnt == ScW'(N)) settled_q <= 1'b1;
        else                       strobe_cnt <= strobe_cnt + ScW'(1);
      end
    end
  end

  assign bus.Output       = out_q;
  assign bus.Output_Valid = valid_q;
  assign bus.Settled      = settled_q;
endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Scoreboard bench for sigma_delta_decimator: the stimulus pushes expected strobes,
// a negedge monitor pops and compares them.
module tb_sigma_delta_decimator;
  localparam int NSTG = 4;
  localparam int R    = 64;

  typedef struct {
    int          cyc;
    logic [23:0] val;
    bit          chk;
    bit          settled;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   strobe_idx = 0;
  exp_t sb[$];

  sigma_delta_decimator_if #(.InputN(8), .OutputN(24)) bus ();

  sigma_delta_decimator #(.InputN(8), .OutputN(24), .N(NSTG), .RLog2(6)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge Clk) begin
    if (Reset && bus.Output_Valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: strobe at cycle %0d, none expected", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL strobe_cycle: got cycle %0d want %0d", cyc, e.cyc);
        end
        checks++;
        if (bus.Settled !== e.settled) begin
          errors++;
          $display("FAIL settled_at_strobe: got %b want %b (cycle %0d)", bus.Settled, e.settled, cyc);
        end
        if (e.chk) begin
          checks++;
          if (bus.Output !== e.val) begin
            errors++;
            $display("FAIL output_value: got %h want %h (cycle %0d)", bus.Output, e.val, cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    bus.Clk_Ena = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    strobe_idx = 0;
  endtask

  // Feeds nstrobe*R enabled samples (alternating in_a/in_b), one enabled cycle in ena_every.
  task automatic run(input logic [7:0] in_a, input logic [7:0] in_b, input int ena_every,
                     input int nstrobe, input logic [23:0] expv, input bit chk_all);
    int n_en = 0;
    int phase = 0;
    exp_t e;
    while (n_en < nstrobe * R) begin
      @(negedge Clk);
      if (phase == 0) begin
        bus.Clk_Ena = 1'b1;
        bus.Input = (n_en % 2 == 0) ? in_a : in_b;
        n_en++;
        if (n_en % R == 0) begin
          strobe_idx++;
          e.cyc = cyc + NSTG + 3;
          e.val = expv;
          e.chk = chk_all || (strobe_idx > NSTG);
          e.settled = (strobe_idx >= NSTG + 1);
          sb.push_back(e);
        end
      end else begin
        bus.Clk_Ena = 1'b0;
        bus.Input = 8'($urandom);
      end
      phase = (phase + 1) % ena_every;
    end
    @(negedge Clk);
    bus.Clk_Ena = 1'b0;
    repeat (NSTG + 8) @(negedge Clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bus.Clk_Ena = 1'b0;
    bus.Input = 8'h80;
    repeat (2) @(negedge Clk);
    check("reset_output", 32'(bus.Output), 32'h800000);
    check("reset_valid", 32'(bus.Output_Valid), 32'd0);
    check("reset_settled", 32'(bus.Settled), 32'd0);
    Reset = 1'b1;

    run(8'h80, 8'h80, 1, 6, 24'h800000, 1'b1);
    check("settled_after_run", 32'(bus.Settled), 32'd1);

    do_reset();
    run(8'hFF, 8'hFF, 1, 6, 24'hFF0000, 1'b0);

    do_reset();
    run(8'h00, 8'h00, 1, 6, 24'h000000, 1'b0);

    do_reset();
    run(8'h00, 8'hFF, 1, 6, 24'h7F8000, 1'b0);

    do_reset();
    run(8'hFF, 8'hFF, 4, 6, 24'hFF0000, 1'b0);

    do_reset();
    run(8'hFF, 8'hFF, 1, 6, 24'hFF0000, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      bus.Clk_Ena = 1'b1;
      bus.Input = 8'hFF;
    end
    @(negedge Clk);
    check("pre_reset_settled", 32'(bus.Settled), 32'd1);
    check("pre_reset_output", 32'(bus.Output), 32'hFF0000);
    Reset = 1'b0;
    bus.Clk_Ena = 1'b0;
    #1;
    check("midframe_reset_output", 32'(bus.Output), 32'h800000);
    check("midframe_reset_valid", 32'(bus.Output_Valid), 32'd0);
    check("midframe_reset_settled", 32'(bus.Settled), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    strobe_idx = 0;
    run(8'h80, 8'h80, 1, 2, 24'h800000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
